// File: rtl/addsub_cmp_sched_pkg.sv
// Shared types, default sizes and helpers for the add/sub-compare scheduler.
package addsub_cmp_sched_pkg;
  `include "addsub_cmp_sched_defs.vh"

  localparam int DEF_W    = 4;
  localparam int DEF_NREQ = 4;
  localparam int DEF_IDW  = 2;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction
endpackage

// File: rtl/addsub_cmp_sched_if.sv
// Requester/consumer bundle of the add/sub-compare scheduler.
interface addsub_cmp_sched_if
  import addsub_cmp_sched_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = DEF_IDW
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ack;
  logic              busy;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_gt;
  logic              rsp_eq;
  logic              rsp_ls;
  logic              rsp_err;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output req_valid, req_sub, req_a, req_b, rsp_ready,
    input  req_ack, busy, rsp_valid, rsp_id, rsp_sum, rsp_gt, rsp_eq, rsp_ls, rsp_err, err_cnt
  );

  modport slave (
    input  req_valid, req_sub, req_a, req_b, rsp_ready,
    output req_ack, busy, rsp_valid, rsp_id, rsp_sum, rsp_gt, rsp_eq, rsp_ls, rsp_err, err_cnt
  );
endinterface

// File: rtl/addsub_cmp_sched_defs.vh
// FSM state encodings for the shared add/sub-compare scheduler.
`ifndef ADDSUB_CMP_SCHED_DEFS_VH
`define ADDSUB_CMP_SCHED_DEFS_VH
localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_EXEC = 2'd1;
localparam logic [1:0] ST_RESP = 2'd2;
`endif

// File: rtl/addsub_cmp_unit.sv
// Combinational W-bit add/subtract with signed compare flags and overflow detect.
module addsub_cmp_unit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         gt,
  output logic         eq,
  output logic         ls,
  output logic         err
);
  logic [W-1:0] b_x_s;
  logic [W:0]   full_s;
  logic [W-1:0] low_s;

  assign b_x_s  = b ^ {W{sub}};
  assign full_s = {1'b0, a} + {1'b0, b_x_s} + {{W{1'b0}}, sub};
  // low_s[W-1] is the carry into the sign bit
  assign low_s  = {1'b0, a[W-2:0]} + {1'b0, b_x_s[W-2:0]} + {{(W-1){1'b0}}, sub};

  assign sum = full_s[W-1:0];
  assign err = full_s[W] ^ low_s[W-1];
  assign eq  = !err && (sum == {W{1'b0}});
  assign ls  = !err && sum[W-1];
  assign gt  = !err && !sum[W-1] && (sum != {W{1'b0}});
endmodule

// File: rtl/addsub_cmp_sched.sv
// Round-robin scheduler sharing one add/sub-compare unit among NREQ requesters,
// with a registered result held until the consumer takes it.
module addsub_cmp_sched
  import addsub_cmp_sched_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = DEF_IDW
) (
  input  logic                clk,
  input  logic                rst,
  addsub_cmp_sched_if.slave   bus
);
  state_t           state_r, next_state_s;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   grant_s, cand_s;
  logic             found_s, hit_s, capture_s;
  logic [NREQ-1:0]  ack_s;
  logic [W-1:0]     a_r, b_r;
  logic             sub_r;
  logic [IDW-1:0]   id_r;
  logic [W-1:0]     sum_s;
  logic             gt_s, eq_s, ls_s, err_s;
  logic             rsp_valid_r, rsp_gt_r, rsp_eq_r, rsp_ls_r, rsp_err_r;
  logic [IDW-1:0]   rsp_id_r;
  logic [W-1:0]     rsp_sum_r;
  logic [CNT_W-1:0] err_cnt_r;

  addsub_cmp_unit #(.W(W)) u_unit (
    .a(a_r), .b(b_r), .sub(sub_r),
    .sum(sum_s), .gt(gt_s), .eq(eq_s), .ls(ls_s), .err(err_s)
  );

  // Round-robin search: first valid requester at or after ptr_r
  always_comb begin
    found_s = 1'b0;
    grant_s = {IDW{1'b0}};
    cand_s  = {IDW{1'b0}};
    hit_s   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s  = IDW'((int'(ptr_r) + i) % NREQ);
      hit_s   = !found_s && bus.req_valid[cand_s];
      grant_s = hit_s ? cand_s : grant_s;
      found_s = found_s | hit_s;
    end
  end

  // Next-state and grant decode; reset suppresses any grant in its cycle
  always_comb begin
    next_state_s = state_r;
    ack_s        = {NREQ{1'b0}};
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s && !rst) begin
          next_state_s   = EXEC;
          ack_s[grant_s] = 1'b1;
          capture_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: next_state_s = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, operand latch, result registers and saturating overflow counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= {IDW{1'b0}};
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      sub_r       <= 1'b0;
      id_r        <= {IDW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {IDW{1'b0}};
      rsp_sum_r   <= {W{1'b0}};
      rsp_gt_r    <= 1'b0;
      rsp_eq_r    <= 1'b0;
      rsp_ls_r    <= 1'b0;
      rsp_err_r   <= 1'b0;
      err_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (capture_s) begin
        a_r   <= bus.req_a[int'(grant_s)*W +: W];
        b_r   <= bus.req_b[int'(grant_s)*W +: W];
        sub_r <= bus.req_sub[grant_s];
        id_r  <= grant_s;
        ptr_r <= IDW'((int'(grant_s) + 1) % NREQ);
      end
      if (state_r == EXEC) begin
        rsp_valid_r <= 1'b1;
        rsp_id_r    <= id_r;
        rsp_sum_r   <= sum_s;
        rsp_gt_r    <= gt_s;
        rsp_eq_r    <= eq_s;
        rsp_ls_r    <= ls_s;
        rsp_err_r   <= err_s;
        err_cnt_r   <= err_s ? sat_inc(err_cnt_r) : err_cnt_r;
      end else if ((state_r == RESP) && bus.rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign bus.req_ack   = ack_s;
  assign bus.busy      = (state_r != IDLE);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_sum   = rsp_sum_r;
  assign bus.rsp_gt    = rsp_gt_r;
  assign bus.rsp_eq    = rsp_eq_r;
  assign bus.rsp_ls    = rsp_ls_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.err_cnt   = err_cnt_r;
endmodule

// File: tb/tb_addsub_cmp_sched.sv
// Directed self-checking bench for addsub_cmp_sched.
module tb_addsub_cmp_sched;
  localparam int W    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  addsub_cmp_sched_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus ();

  addsub_cmp_sched #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    bus.req_sub[id]      = sub;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b expected 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d expected 0", bus.err_cnt); else pass_cnt++;
    total_cnt++; if (bus.rsp_sum !== 4'd0) $display("FAIL reset_rsp_sum: got %h expected 0", bus.rsp_sum); else pass_cnt++;
    total_cnt++; if (bus.req_ack !== 4'b0000) $display("FAIL reset_ack: got %b expected 0000", bus.req_ack); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    tick();
    set_op(0, 4'd3, 4'd2, 1'b1);
    bus.req_valid = 4'b0001;
    #1;
    total_cnt++; if (bus.req_ack !== 4'b0001) $display("FAIL basic_ack: got %b expected 0001", bus.req_ack); else pass_cnt++;
    tick();
    bus.req_valid = 4'b0000;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL basic_t1_valid: got %0b expected 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL basic_t1_busy: got %0b expected 1", bus.busy); else pass_cnt++;
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL basic_t2_valid: got %0b expected 1", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.rsp_sum !== 4'd1) $display("FAIL basic_sum: got %h expected 1", bus.rsp_sum); else pass_cnt++;
    total_cnt++; if ({bus.rsp_gt, bus.rsp_eq, bus.rsp_ls, bus.rsp_err} !== 4'b1000) $display("FAIL basic_flags: got %b expected 1000", {bus.rsp_gt, bus.rsp_eq, bus.rsp_ls, bus.rsp_err}); else pass_cnt++;
    total_cnt++; if (bus.rsp_id !== 2'd0) $display("FAIL basic_id: got %0d expected 0", bus.rsp_id); else pass_cnt++;
    bus.rsp_ready = 1'b1;
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL basic_done_valid: got %0b expected 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL basic_done_busy: got %0b expected 0", bus.busy); else pass_cnt++;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_overflow();
    tick();
    set_op(2, 4'd7, 4'd1, 1'b0);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    total_cnt++; if (bus.req_ack !== 4'b0100) $display("FAIL ovf_ack: got %b expected 0100", bus.req_ack); else pass_cnt++;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    total_cnt++; if (bus.rsp_sum !== 4'b1000) $display("FAIL ovf_sum: got %b expected 1000", bus.rsp_sum); else pass_cnt++;
    total_cnt++; if ({bus.rsp_gt, bus.rsp_eq, bus.rsp_ls, bus.rsp_err} !== 4'b0001) $display("FAIL ovf_flags: got %b expected 0001", {bus.rsp_gt, bus.rsp_eq, bus.rsp_ls, bus.rsp_err}); else pass_cnt++;
    total_cnt++; if (bus.rsp_id !== 2'd2) $display("FAIL ovf_id: got %0d expected 2", bus.rsp_id); else pass_cnt++;
    total_cnt++; if (bus.err_cnt !== 8'd1) $display("FAIL ovf_err_cnt: got %0d expected 1", bus.err_cnt); else pass_cnt++;
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL ovf_done_valid: got %0b expected 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.rsp_sum !== 4'b1000) $display("FAIL ovf_sum_held: got %b expected 1000", bus.rsp_sum); else pass_cnt++;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int          ids [4] = '{0, 1, 3, 0};
    logic [3:0]  es;
    logic [2:0]  ef;
    tick();
    rst = 1'b1;
    set_op(0, 4'd5, 4'd5, 1'b1);
    set_op(1, 4'd2, 4'd5, 1'b0);
    set_op(3, 4'd2, 4'd5, 1'b1);
    bus.req_valid = 4'b1011;
    bus.rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      case (ids[k])
        0:       begin es = 4'h0; ef = 3'b010; end
        1:       begin es = 4'h7; ef = 3'b100; end
        default: begin es = 4'hD; ef = 3'b001; end
      endcase
      total_cnt++; if (bus.req_ack !== (4'b0001 << ids[k])) $display("FAIL rr_ack%0d: got %b expected %b", k, bus.req_ack, 4'b0001 << ids[k]); else pass_cnt++;
      tick();
      total_cnt++; if (bus.req_ack !== 4'b0000) $display("FAIL rr_exec_ack%0d: got %b expected 0000", k, bus.req_ack); else pass_cnt++;
      tick();
      total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(ids[k])) $display("FAIL rr_rsp%0d: got valid=%0b id=%0d expected valid=1 id=%0d", k, bus.rsp_valid, bus.rsp_id, ids[k]); else pass_cnt++;
      total_cnt++; if (bus.rsp_sum !== es || {bus.rsp_gt, bus.rsp_eq, bus.rsp_ls} !== ef) $display("FAIL rr_result%0d: got sum=%h gel=%b expected sum=%h gel=%b", k, bus.rsp_sum, {bus.rsp_gt, bus.rsp_eq, bus.rsp_ls}, es, ef); else pass_cnt++;
      if (k == 3) bus.req_valid = 4'b0000;
      tick();
    end
  endtask

  task automatic test_backpressure();
    set_op(1, 4'd1, 4'd1, 1'b0);
    set_op(2, 4'd4, 4'd6, 1'b1);
    bus.req_valid = 4'b0110;
    bus.rsp_ready = 1'b0;
    #1;
    total_cnt++; if (bus.req_ack !== 4'b0010) $display("FAIL bp_ack: got %b expected 0010", bus.req_ack); else pass_cnt++;
    tick();
    bus.req_valid = 4'b0100;
    tick();
    for (int s = 0; s < 6; s++) begin
      total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 4'd2 || bus.rsp_id !== 2'd1 || bus.rsp_gt !== 1'b1) $display("FAIL bp_hold%0d: got valid=%0b sum=%h id=%0d gt=%0b expected 1 2 1 1", s, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.rsp_gt); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b1 || bus.req_ack !== 4'b0000) $display("FAIL bp_stall%0d: got busy=%0b ack=%b expected busy=1 ack=0000", s, bus.busy, bus.req_ack); else pass_cnt++;
      if (s == 5) bus.rsp_ready = 1'b1;
      tick();
    end
    total_cnt++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) $display("FAIL bp_idle: got busy=%0b valid=%0b expected 0 0", bus.busy, bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.req_ack !== 4'b0100) $display("FAIL bp_next_ack: got %b expected 0100", bus.req_ack); else pass_cnt++;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    total_cnt++; if (bus.rsp_id !== 2'd2 || bus.rsp_sum !== 4'hE || bus.rsp_ls !== 1'b1) $display("FAIL bp_second: got id=%0d sum=%h ls=%0b expected 2 e 1", bus.rsp_id, bus.rsp_sum, bus.rsp_ls); else pass_cnt++;
    tick();
  endtask

  task automatic test_withdraw();
    set_op(0, 4'd6, 4'd6, 1'b1);
    set_op(1, 4'd1, 4'd2, 1'b0);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    #1;
    total_cnt++; if (bus.req_ack !== 4'b0001) $display("FAIL wd_ack0: got %b expected 0001", bus.req_ack); else pass_cnt++;
    tick();
    bus.req_valid = 4'b0010;
    #1;
    total_cnt++; if (bus.req_ack !== 4'b0000) $display("FAIL wd_exec_ack: got %b expected 0000", bus.req_ack); else pass_cnt++;
    tick();
    bus.req_valid = 4'b0000;
    total_cnt++; if (bus.rsp_id !== 2'd0 || bus.rsp_eq !== 1'b1) $display("FAIL wd_rsp: got id=%0d eq=%0b expected 0 1", bus.rsp_id, bus.rsp_eq); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      tick();
      total_cnt++; if (bus.req_ack !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL wd_no_ack%0d: got ack=%b busy=%0b expected 0000 0", c, bus.req_ack, bus.busy); else pass_cnt++;
    end
  endtask

  task automatic test_saturate();
    int n;
    n = 0;
    set_op(0, 4'd7, 4'd1, 1'b0);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 1000 && n < 260; c++) begin
      if (bus.req_ack[0] === 1'b1) begin
        n++;
        if (n == 101) begin
          total_cnt++; if (bus.err_cnt !== 8'd100) $display("FAIL sat_mid: got %0d expected 100", bus.err_cnt); else pass_cnt++;
        end
      end
      tick();
    end
    bus.req_valid = 4'b0000;
    tick();
    tick();
    total_cnt++; if (n != 260) $display("FAIL sat_op_count: got %0d expected 260", n); else pass_cnt++;
    total_cnt++; if (bus.err_cnt !== 8'd255) $display("FAIL sat_err_cnt: got %0d expected 255", bus.err_cnt); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL sat_idle: got %0b expected 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_resp();
    set_op(2, 4'd1, 4'd1, 1'b0);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    #1;
    total_cnt++; if (bus.req_ack !== 4'b0100) $display("FAIL rmr_ack: got %b expected 0100", bus.req_ack); else pass_cnt++;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL rmr_resp: got %0b expected 1", bus.rsp_valid); else pass_cnt++;
    rst = 1'b1;
    bus.req_valid = 4'b1001;
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rmr_cleared: got valid=%0b busy=%0b expected 0 0", bus.rsp_valid, bus.busy); else pass_cnt++;
    total_cnt++; if (bus.err_cnt !== 8'd0) $display("FAIL rmr_err_cnt: got %0d expected 0", bus.err_cnt); else pass_cnt++;
    total_cnt++; if (bus.req_ack !== 4'b0000) $display("FAIL rmr_ack_in_rst: got %b expected 0000", bus.req_ack); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (bus.req_ack !== 4'b0001) $display("FAIL rmr_first_grant: got %b expected 0001", bus.req_ack); else pass_cnt++;
    tick();
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_sub   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_withdraw();
    test_saturate();
    test_reset_mid_resp();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
